// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave control sequencer: state codes,
// keypad limit and the default prescaler length.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTING = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int unsigned KEY_MAX           = 9;
    localparam int unsigned TICKS_PER_SEC_DEF = 50_000_000;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts run cycles and strobes tick_o in the cycle it wraps.
// restart_i zeroes the count and takes priority over run_i.
module tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned W = $clog2(TICKS_PER_SEC);
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] count_q;

    assign tick_o = run_i && (count_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            count_q <= '0;
        end else if (run_i) begin
            count_q <= tick_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_control.sv
// Microwave cook-cycle sequencer: loads keypad digits into the countdown
// timer, paces it with one enable pulse per second, and handles pause/cancel/done.
module microwave_control
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_enable,
    output logic       timer_clear,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic       loadn_q, loadn_d;
    logic       enable_q, enable_d;
    logic       tclear_q, tclear_d;
    logic       mag_q, done_q;
    logic       start_prev_q, stop_prev_q, door_prev_q;
    logic       start_edge, stop_edge, door_fall, key_ok, can_start;
    logic       tick, restart;

    assign start_edge = start & ~start_prev_q;
    assign stop_edge  = stop & ~stop_prev_q;
    assign door_fall  = door_prev_q & ~door_closed;
    assign key_ok     = key_valid && (key_code <= 4'(KEY_MAX));
    assign can_start  = start_edge && door_closed && !timer_zero;

    // The count is kept across PAUSED; only a fresh cook or idle/done clears it.
    assign restart = ((state_q == SETTING) && (state_d == COOKING)) ||
                     ((state_q != state_d) && ((state_d == IDLE) || (state_d == DONE)));

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk_i    (clock),
        .rst_i    (clear),
        .run_i    (state_q == COOKING),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        loadn_d  = 1'b1;
        tclear_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_ok) begin
                    data_d  = key_code;
                    loadn_d = 1'b0;
                    state_d = SETTING;
                end
            end
            SETTING: begin
                if (stop_edge) begin
                    tclear_d = 1'b1;
                    state_d  = IDLE;
                end else if (can_start) begin
                    state_d = COOKING;
                end else if (key_ok) begin
                    data_d  = key_code;
                    loadn_d = 1'b0;
                end
            end
            COOKING: begin
                if (timer_zero) begin
                    state_d = DONE;
                end else if (!door_closed || stop_edge) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (stop_edge) begin
                    tclear_d = 1'b1;
                    state_d  = IDLE;
                end else if (can_start) begin
                    state_d = COOKING;
                end
            end
            DONE: begin
                if (door_fall || stop_edge) begin
                    state_d = IDLE;
                end else if (key_ok) begin
                    data_d  = key_code;
                    loadn_d = 1'b0;
                    state_d = SETTING;
                end
            end
            default: state_d = IDLE;
        endcase
        enable_d = tick && (state_d == COOKING);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            data_q       <= '0;
            loadn_q      <= 1'b1;
            enable_q     <= 1'b0;
            tclear_q     <= 1'b0;
            mag_q        <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            door_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            loadn_q      <= loadn_d;
            enable_q     <= enable_d;
            tclear_q     <= tclear_d;
            mag_q        <= (state_d == COOKING);
            done_q       <= (state_d == DONE);
            start_prev_q <= start;
            stop_prev_q  <= stop;
            door_prev_q  <= door_closed;
        end
    end

    assign timer_data   = data_q;
    assign timer_loadn  = loadn_q;
    assign timer_enable = enable_q;
    assign timer_clear  = tclear_q;
    assign mag_on       = mag_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_microwave_control.sv
// Directed bench for microwave_control with TICKS_PER_SEC=4; expected values
// are hand-derived cycle by cycle from the sequencer's behaviour.
module tb_microwave_control;

    logic       clock = 1'b0;
    logic       clear, start, stop, door_closed, key_valid, timer_zero;
    logic [3:0] key_code;
    logic [3:0] timer_data;
    logic       timer_loadn, timer_enable, timer_clear, mag_on, done;
    logic [2:0] state;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    microwave_control #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .timer_zero  (timer_zero),
        .timer_data  (timer_data),
        .timer_loadn (timer_loadn),
        .timer_enable(timer_enable),
        .timer_clear (timer_clear),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle so outputs reflect inputs sampled at it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One-cycle key strobe; checks the load pulse and the following cycle.
    task automatic press(input logic [3:0] k, input logic exp_loadn,
                         input logic [3:0] exp_data, input logic [2:0] exp_state);
        key_valid = 1'b1;
        key_code  = k;
        cyc();
        key_valid = 1'b0;
        check("key_loadn", timer_loadn, exp_loadn);
        check("key_data",  timer_data,  exp_data);
        check("key_state", state,       exp_state);
        cyc();
        check("key_loadn_rel", timer_loadn, 1'b1);
        check("key_data_hold", timer_data,  exp_data);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        key_valid = 1'b0; key_code = '0; timer_zero = 1'b0;

        // Reset
        cyc(); cyc();
        check("rst_state",  state,        3'd0);
        check("rst_loadn",  timer_loadn,  1'b1);
        check("rst_data",   timer_data,   4'd0);
        check("rst_enable", timer_enable, 1'b0);
        check("rst_tclear", timer_clear,  1'b0);
        check("rst_mag",    mag_on,       1'b0);
        check("rst_done",   done,         1'b0);
        clear = 1'b0;
        cyc();

        // Key entry: 12 is ignored, data holds the last accepted digit
        press(4'd1,  1'b0, 4'd1, 3'd1);
        press(4'd3,  1'b0, 4'd3, 3'd1);
        press(4'd12, 1'b1, 4'd3, 3'd1);
        press(4'd0,  1'b0, 4'd0, 3'd1);

        // Full cook: pulses 4, 8, 12 cycles after mag_on rises
        start = 1'b1;
        cyc();
        check("cook_state", state,  3'd2);
        check("cook_mag",   mag_on, 1'b1);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("cook_enable", timer_enable, (k % 4 == 0));
        end
        timer_zero = 1'b1;
        cyc();
        check("done_state",  state,        3'd4);
        check("done_done",   done,         1'b1);
        check("done_mag",    mag_on,       1'b0);
        check("done_enable", timer_enable, 1'b0);
        timer_zero = 1'b0;

        // Key in DONE behaves as in IDLE
        press(4'd5, 1'b0, 4'd5, 3'd1);
        check("set_done_low", done, 1'b0);

        // Pause by door, then resume from held count
        start = 1'b1;
        cyc();
        check("c2_mag", mag_on, 1'b1);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("c2_enable", timer_enable, (k == 4));
        end
        cyc();
        door_closed = 1'b0;
        cyc();
        check("pause_state",  state,        3'd3);
        check("pause_mag",    mag_on,       1'b0);
        check("pause_enable", timer_enable, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("pause_noen",  timer_enable, 1'b0);
            check("pause_state", state,        3'd3);
        end
        door_closed = 1'b1;
        start = 1'b1;
        cyc();
        check("resume_state", state,  3'd2);
        check("resume_mag",   mag_on, 1'b1);
        start = 1'b0;
        cyc();
        check("resume_en1", timer_enable, 1'b0);
        cyc();
        check("resume_en2", timer_enable, 1'b1);

        // Stop edge pauses, second stop edge cancels with timer_clear
        stop = 1'b1;
        cyc();
        check("stop_pause", state,       3'd3);
        check("stop_noclr", timer_clear, 1'b0);
        stop = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        check("cancel_state",  state,       3'd0);
        check("cancel_tclear", timer_clear, 1'b1);
        stop = 1'b0;
        cyc();
        check("cancel_tclear_rel", timer_clear, 1'b0);

        // Start rejected: door open, then timer already zero
        press(4'd7, 1'b0, 4'd7, 3'd1);
        door_closed = 1'b0;
        start = 1'b1;
        cyc();
        check("rej_door", state, 3'd1);
        start = 1'b0; door_closed = 1'b1;
        cyc();
        timer_zero = 1'b1;
        start = 1'b1;
        cyc();
        check("rej_zero",     state,  3'd1);
        check("rej_zero_mag", mag_on, 1'b0);
        start = 1'b0; timer_zero = 1'b0;
        cyc();

        // Simultaneous zero and door open: zero wins
        start = 1'b1;
        cyc();
        check("sim_cook", state, 3'd2);
        start = 1'b0;
        cyc();
        timer_zero = 1'b1; door_closed = 1'b0;
        cyc();
        check("sim_state", state,  3'd4);
        check("sim_done",  done,   1'b1);
        check("sim_mag",   mag_on, 1'b0);
        timer_zero = 1'b0; door_closed = 1'b1;
        cyc();
        check("done_hold", state, 3'd4);
        door_closed = 1'b0;
        cyc();
        check("door_fall_state",  state,       3'd0);
        check("door_fall_tclear", timer_clear, 1'b0);
        check("door_fall_done",   done,        1'b0);
        door_closed = 1'b1;
        cyc();

        // Reset mid-cook
        press(4'd2, 1'b0, 4'd2, 3'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        check("mid_mag", mag_on, 1'b1);
        clear = 1'b1;
        cyc();
        check("mid_state",  state,        3'd0);
        check("mid_mag0",   mag_on,       1'b0);
        check("mid_enable", timer_enable, 1'b0);
        check("mid_tclear", timer_clear,  1'b0);
        check("mid_loadn",  timer_loadn,  1'b1);
        check("mid_data",   timer_data,   4'd0);
        clear = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microwave_control.md
# microwave_control

Control sequencer upstream of the microwave countdown timer. It accepts keypad digits and shifts them into the timer through its serial load port. It runs the cook cycle: magnetron on, one timer-enable pulse per second, pause on door-open or stop, and done on timer zero. It is the sole driver of the timer's `data_in`, `loadn`, `enable` and `clear` inputs and the sole consumer of the timer's `zero` output.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per timer decrement; must be ≥ 2.
- `clock` in 1: the only clock; all state changes on its rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `start` in 1: debounced start button, active-high level; rising edge detected internally.
- `stop` in 1: debounced stop/cancel button, active-high level; rising edge detected internally.
- `door_closed` in 1: 1 = door closed.
- `key_valid` in 1: one-cycle strobe marking `key_code` valid.
- `key_code` in 4: keypad digit; values 10–15 are ignored.
- `timer_zero` in 1: timer's `zero` output.
- `timer_data` out 4: drives timer `data_in`.
- `timer_loadn` out 1: drives timer `loadn`, active-low.
- `timer_enable` out 1: drives timer `enable`, a one-cycle pulse.
- `timer_clear` out 1: drives timer `clear`, a one-cycle pulse.
- `mag_on` out 1: magnetron enable.
- `done` out 1: cook-complete indicator.
- `state` out 3: current state code.

## Operation
- States and codes: IDLE=0, SETTING=1, COOKING=2, PAUSED=3, DONE=4.
- Edge detect: `start` and `stop` each have a previous-value register, cleared to 0 by reset. An edge is `x & ~x_prev`.
- IDLE, SETTING or DONE, on `key_valid` with `key_code` ≤ 9:
  - `timer_data` <= `key_code`; `timer_loadn` low for one cycle.
  - Next state is SETTING.
- `key_valid` is ignored in COOKING and PAUSED.
- SETTING, or PAUSED:
  - start edge with `door_closed`=1 and `timer_zero`=0 goes to COOKING.
  - start edge under any other condition is ignored.
- SETTING or PAUSED, stop edge: go to IDLE and pulse `timer_clear` for one cycle.
- COOKING:
  - `mag_on`=1; prescaler runs.
  - `timer_zero`=1 goes to DONE.
  - Otherwise, `door_closed`=0 or a stop edge goes to PAUSED.
- PAUSED: prescaler holds its count; resuming continues from the held count.
- Prescaler reset points: the count is reset to 0 on entry to COOKING from SETTING, and on any transition into IDLE or DONE.
- DONE: `done`=1. A stop edge, or `door_closed` falling (1→0), goes to IDLE with no `timer_clear`. A valid key is handled as in IDLE.
- Priority within one cycle, highest first: `clear` > `timer_zero` (COOKING only) > door open > stop edge > start edge > `key_valid`.

## Timing
- All outputs are registered. Each output responds one cycle after the input sample that caused it.
- Reset values:
  - state IDLE; `timer_data`=0; `timer_loadn`=1; `timer_enable`=0; `timer_clear`=0; `mag_on`=0; `done`=0.
  - Prescaler = 0; edge registers = 0.
- `timer_loadn` is low for exactly one cycle per accepted key. `timer_data` is stable during that cycle and holds its value afterwards.
- Prescaler:
  - Counter width is `$clog2(TICKS_PER_SEC)`.
  - It increments each COOKING cycle. At `TICKS_PER_SEC-1` it wraps to 0 and `timer_enable` is 1 in the following cycle.
  - First pulse: exactly `TICKS_PER_SEC` cycles after `mag_on` rises, given a fresh count.
- `timer_enable` is never asserted outside COOKING. `mag_on` drops in the same cycle the state leaves COOKING.
- `timer_zero` is sampled every COOKING cycle, so DONE is entered one cycle after zero appears.
- Reset mid-operation: all outputs return to reset values on the next edge. No `timer_clear` pulse is generated; the system reset clears the timer.

## Structure
- Shared package `microwave_pkg`:
  - state codes;
  - `KEY_MAX` = 9;
  - `TICKS_PER_SEC` default.
- Sub-module `tick_gen`: prescaler with `run` and `restart` inputs and a one-cycle `tick` output, parameterised by `TICKS_PER_SEC`.
- Everything else is flat in `microwave_control`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- **Reset:** assert `clear` 2 cycles → `state`=0, `timer_loadn`=1, all other outputs 0. Assert `clear` again mid-COOKING → `mag_on`=0 and `state`=0 one cycle later.
- **Key entry:** keys 1, 3, 12, 0 → `timer_loadn` pulses three times with `timer_data` 1, 3, 0; key 12 produces no pulse; `state`=1.
- **Full cook:** from SETTING, door closed, start edge → `mag_on`=1. `timer_enable` pulses 4, 8, 12 cycles after `mag_on` rises. Force `timer_zero`=1 after the third pulse → `state`=4, `done`=1, `mag_on`=0.
- **Pause by door, then resume:** door opens 2 cycles after a pulse → PAUSED, no pulses while open. Close the door and give a start edge → next pulse 2 cycles after `mag_on` rises.
- **Cancel from PAUSED:** stop edge in PAUSED → one-cycle `timer_clear` pulse, `state`=0.
- **Start rejected:**
  - start edge in SETTING with door open → remains SETTING;
  - start edge in SETTING with `timer_zero`=1 → remains SETTING.
- **Simultaneous events:** in COOKING, `timer_zero`=1 and door open in the same cycle → DONE, not PAUSED.
